// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 9-bit core: owns the PC, steps each
// instruction through FETCH/EXEC/MEM and drives the datapath strobes.
module multicycle_sequencer #(
    parameter int PW = 10,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [PW-1:0] prog_len,
    input  logic [8:0]    instr,
    input  logic          ne_flag,
    input  logic [PW-1:0] br_target,
    input  logic          mem_ack,
    output logic [PW-1:0] pc,
    output logic          ir_en,
    output logic [2:0]    alu_op,
    output logic          alu_src,
    output logic          reg_write,
    output logic          mem_to_reg,
    output logic          mem_req,
    output logic          mem_we,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_DONE
    } state_t;

    localparam logic [PW-1:0] PC_ONE = PW'(1);
    localparam logic [CW-1:0] CC_ONE = CW'(1);

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] pc_next;
    logic [PW-1:0] len_q;
    logic          is_store;
    logic          advance;
    logic [2:0]    opcode;
    logic [5:0]    unused_instr_bits;

    assign opcode            = instr[8:6];
    assign unused_instr_bits = instr[5:0];

    // The store flag is captured in EXEC so MEM does not depend on the IR holding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            len_q       <= '0;
            is_store    <= 1'b0;
            cycle_count <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if ((state == S_IDLE || state == S_DONE) && start) begin
                len_q       <= prog_len;
                cycle_count <= '0;
            end else if (busy && cycle_count != {CW{1'b1}}) begin
                cycle_count <= cycle_count + CC_ONE;
            end
            if (state == S_EXEC) begin
                is_store <= (opcode == 3'b100);
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        advance    = 1'b0;
        ir_en      = 1'b0;
        alu_op     = 3'b111;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    pc_next    = '0;
                    state_next = (prog_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                busy       = 1'b1;
                ir_en      = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                case (opcode)
                    3'b000: begin alu_op = 3'b000; reg_write = 1'b1; pc_next = pc + PC_ONE; advance = 1'b1; end
                    3'b001: begin alu_op = 3'b001; reg_write = 1'b1; pc_next = pc + PC_ONE; advance = 1'b1; end
                    3'b010: begin alu_op = 3'b010; reg_write = 1'b1; pc_next = pc + PC_ONE; advance = 1'b1; end
                    3'b101: begin alu_op = 3'b011; reg_write = 1'b1; pc_next = pc + PC_ONE; advance = 1'b1; end
                    3'b111: begin
                        alu_op    = 3'b100;
                        alu_src   = 1'b1;
                        reg_write = 1'b1;
                        pc_next   = pc + PC_ONE;
                        advance   = 1'b1;
                    end
                    3'b110: begin
                        pc_next = ne_flag ? br_target : pc + PC_ONE;
                        advance = 1'b1;
                    end
                    default: begin
                        state_next = S_MEM;
                    end
                endcase
            end
            S_MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ack) begin
                    reg_write  = !is_store;
                    mem_to_reg = !is_store;
                    pc_next    = pc + PC_ONE;
                    advance    = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // A branch target at or past the program end finishes the run too.
        if (advance) begin
            state_next = (pc_next >= len_q) ? S_DONE : S_FETCH;
        end
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control sequencer for the 9-bit, 3-bit-opcode core.
- Owns the program counter and steps each instruction through FETCH, EXEC and an optional MEM phase.
- Drives the datapath strobes: IR load, ALU op, register write, and the data-memory request/ack handshake.
- Provides the top-level start/done handshake and a cycle counter for benchmarking program runs.

Parameters:
- PW, 10, program counter and program length width.
- CW, 16, cycle counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a program run; sampled only in IDLE or DONE.
- prog_len  input  PW  number of instructions; sampled when start is accepted.
- instr  input  9  IR output; opcode is instr[8:6]; valid the cycle after ir_en.
- ne_flag  input  1  ALU compare result; 1 means the operands differ (BNE taken).
- br_target  input  PW  branch target from the branch LUT; valid in EXEC.
- mem_ack  input  1  data memory completes the request; may assert in any cycle of MEM.
- pc  output  PW  program counter, drives the instruction memory address.
- ir_en  output  1  load the IR.
- alu_op  output  3  ALU operation select.
- alu_src  output  1  1 selects the immediate, 0 selects the register operand.
- reg_write  output  1  register file write enable.
- mem_to_reg  output  1  route memory read data to the register write port.
- mem_req  output  1  data memory request.
- mem_we  output  1  data memory write (store).
- busy  output  1  high in FETCH, EXEC and MEM.
- done  output  1  high in DONE.
- cycle_count  output  CW  cycles spent in the current or last run.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pc=0, cycle_count=0.
  - All strobes 0, alu_op=3'b111, done=0, busy=0.
- Strobe defaults in every state unless overridden below: ir_en=0, reg_write=0, mem_to_reg=0, mem_req=0, mem_we=0, alu_src=0, alu_op=3'b111 (y=a+0).
- IDLE/DONE, start=1:
  - pc<=0, cycle_count<=0, latch prog_len.
  - Next state is FETCH, or DONE if prog_len==0.
  - start is ignored while busy.
- FETCH: ir_en=1; next state EXEC.
- EXEC decodes instr[8:6]:
  - 000 add: alu_op=000, reg_write=1.
  - 001 ror: alu_op=001, reg_write=1.
  - 010 nand: alu_op=010, reg_write=1.
  - 101 move: alu_op=011, reg_write=1.
  - 111 set: alu_op=100, alu_src=1, reg_write=1.
  - Each of the above then advances the PC (see below).
  - 110 bne: if ne_flag=1 then next pc=br_target, else next pc=pc+1; reg_write=0.
  - 011 load / 100 store: alu_op=111 (address pass-through); next state MEM; pc unchanged.
- MEM:
  - mem_req=1 every cycle until mem_ack; mem_we=1 for store.
  - Load ack cycle: reg_write=1, mem_to_reg=1 in the same cycle as mem_ack; then PC advance.
  - Store ack cycle: reg_write=0; then PC advance.
  - Stall is unbounded; all strobes are held stable while waiting.
- PC advance (EXEC non-memory ops, MEM on ack):
  - Write the new pc.
  - If new pc >= latched prog_len, next state is DONE; otherwise FETCH.
  - A branch target >= prog_len therefore also ends the run.
  - pc < prog_len <= 2^PW-1 holds, so pc+1 never wraps.
- DONE:
  - done=1, busy=0; pc holds its final value.
  - Stays in DONE until start=1, which restarts exactly as from IDLE.
- cycle_count:
  - Increments by 1 on every cycle in FETCH, EXEC or MEM.
  - Saturates at 2^CW-1; holds in IDLE/DONE.
- Latency:
  - Non-memory instruction: 2 cycles.
  - Memory instruction: 3 + N cycles, where N is the number of stall cycles before mem_ack.
- Simultaneous events: mem_ack arriving on the first MEM cycle means zero stall (3 cycles total).
- Reset mid-run: asserting reset_n=0 aborts the run immediately to the IDLE reset values; no partial register or memory write completes after the reset.

Test Plan:
- prog_len=3, three add instrs -> states FETCH/EXEC repeated ×3, reg_write pulses in cycles 2,4,6, done=1 at cycle 7, pc=3, cycle_count=6.
- bne at pc=1 with ne_flag=1, br_target=0, prog_len=2 -> pc returns to 0; with ne_flag=0 -> pc=2 and done asserts.
- Load, mem_ack delayed 3 cycles -> mem_req high for 4 cycles, reg_write and mem_to_reg high only in the ack cycle, cycle_count=6 for a one-instruction program.
- Store with immediate ack -> mem_req=1, mem_we=1 for one cycle, reg_write=0 throughout, done after 3 cycles.
- prog_len=0, start pulse -> done=1 next cycle, pc=0, cycle_count=0; start held high while busy -> no restart.
- reset_n=0 during MEM -> next cycle pc=0, mem_req=0, busy=0, done=0; a new start then runs normally from pc=0.
